// File: rtl/temac_cfg_sequencer.sv
// AXI-Lite master that programs the TEMAC management registers after reset or restart,
// verifies the speed register by readback, and rewrites it when the RGMII link speed changes.
module temac_cfg_sequencer #(
  parameter logic [7:0] P_RX_CFG_ADDR = 8'h04,
  parameter logic [7:0] P_TX_CFG_ADDR = 8'h08,
  parameter logic [7:0] P_FC_CFG_ADDR = 8'h0C,
  parameter logic [7:0] P_SPEED_ADDR  = 8'h10,
  parameter int         P_START_DELAY = 16,
  parameter int         P_TIMEOUT     = 1023
) (
  input  logic        s_axi_aclk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic [31:0] cfg_rx_word,
  input  logic [31:0] cfg_tx_word,
  input  logic [31:0] cfg_fc_word,
  input  logic [1:0]  inband_clock_speed,
  output logic [7:0]  m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [7:0]  m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error
);

  typedef enum logic [2:0] {IDLE, WAIT_DLY, WR, WR_RESP, RD, RD_DATA, DONE} state_t;

  state_t      state, state_n;
  logic [1:0]  idx, idx_n;
  logic [7:0]  dly_cnt;
  logic [9:0]  to_cnt;
  logic        aw_done, w_done, wr_gap, wr_gap_n;
  logic [1:0]  spd_s1, spd_s2, spd_q, spd_norm, wr_spd;
  logic        chg_seen;
  logic        wr_enter, err_set, to_clr, tmo, phase, start_ok;
  logic        aw_hs, w_hs;
  logic [29:0] unused_rdata;

  assign unused_rdata = m_axi_rdata[29:0];
  assign spd_norm = (spd_q == 2'b11) ? 2'b10 : spd_q;
  assign tmo      = (to_cnt == 10'(P_TIMEOUT - 1));
  assign phase    = (state == WR) || (state == WR_RESP) || (state == RD) || (state == RD_DATA);
  assign start_ok = cfg_start && ((state == IDLE) || (state == DONE));
  assign aw_hs    = m_axi_awvalid && m_axi_awready;
  assign w_hs     = m_axi_wvalid && m_axi_wready;

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    wr_enter = 1'b0;
    wr_gap_n = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_n  = WR;
          idx_n    = 2'd0;
          wr_enter = 1'b1;
        end else begin
          state_n = WAIT_DLY;
        end
      end
      WAIT_DLY: begin
        if (dly_cnt == 8'(P_START_DELAY - 1)) begin
          state_n  = WR;
          idx_n    = 2'd0;
          wr_enter = 1'b1;
        end
      end
      WR: begin
        if (!wr_gap) begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state_n = WR_RESP;
          end else if (tmo) begin
            err_set  = 1'b1;
            wr_gap_n = 1'b1;
            if (idx == 2'd3) state_n = RD;
            else begin
              state_n  = WR;
              idx_n    = idx + 2'd1;
              wr_enter = 1'b1;
            end
          end
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid || tmo) begin
          err_set = !m_axi_bvalid || (m_axi_bresp != 2'b00);
          if (idx == 2'd3) state_n = RD;
          else begin
            state_n  = WR;
            idx_n    = idx + 2'd1;
            wr_enter = 1'b1;
          end
        end
      end
      RD: begin
        if (m_axi_arready) state_n = RD_DATA;
        else if (tmo) begin
          err_set = 1'b1;
          state_n = DONE;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          err_set = (m_axi_rresp != 2'b00) || (m_axi_rdata[31:30] != wr_spd);
          state_n = DONE;
        end else if (tmo) begin
          err_set = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (cfg_start) begin
          state_n  = WR;
          idx_n    = 2'd0;
          wr_enter = 1'b1;
        end else if (chg_seen && (spd_norm != wr_spd)) begin
          // speed-only update: rewrite the last entry and read it back
          state_n  = WR;
          idx_n    = 2'd3;
          wr_enter = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = (state == WR) && !aw_done && !wr_gap;
    m_axi_wvalid  = (state == WR) && !w_done && !wr_gap;
    m_axi_bready  = (state == WR_RESP);
    m_axi_arvalid = (state == RD);
    m_axi_araddr  = (state == RD) ? P_SPEED_ADDR : 8'h00;
    m_axi_rready  = (state == RD_DATA);
    cfg_busy      = phase;
  end

  assign to_clr = (state_n != state) || wr_enter || wr_gap;

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      spd_s1       <= 2'b00;
      spd_s2       <= 2'b00;
      spd_q        <= 2'b00;
      wr_spd       <= 2'b00;
      chg_seen     <= 1'b0;
      dly_cnt      <= 8'd0;
      to_cnt       <= 10'd0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      wr_gap       <= 1'b0;
      m_axi_awaddr <= 8'h00;
      m_axi_wdata  <= 32'h0;
      cfg_done     <= 1'b0;
      cfg_error    <= 1'b0;
    end else begin
      spd_s1   <= inband_clock_speed;
      spd_s2   <= spd_s1;
      spd_q    <= spd_s2;
      chg_seen <= (state == DONE) && (spd_norm != wr_spd);
      dly_cnt  <= (state == WAIT_DLY) ? dly_cnt + 8'd1 : 8'd0;
      to_cnt   <= (!phase || to_clr) ? 10'd0 : to_cnt + 10'd1;
      wr_gap   <= wr_gap_n;

      if (wr_enter) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        case (idx_n)
          2'd0: begin m_axi_awaddr <= P_RX_CFG_ADDR; m_axi_wdata <= cfg_rx_word; end
          2'd1: begin m_axi_awaddr <= P_TX_CFG_ADDR; m_axi_wdata <= cfg_tx_word; end
          2'd2: begin m_axi_awaddr <= P_FC_CFG_ADDR; m_axi_wdata <= cfg_fc_word; end
          default: begin
            m_axi_awaddr <= P_SPEED_ADDR;
            m_axi_wdata  <= {spd_norm, 30'b0};
            wr_spd       <= spd_norm;
          end
        endcase
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end

      if (start_ok) begin
        cfg_done  <= 1'b0;
        cfg_error <= 1'b0;
      end else begin
        if (state == RD_DATA && state_n == DONE) cfg_done <= 1'b1;
        if (err_set) cfg_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_temac_cfg_sequencer.sv
// Bench for temac_cfg_sequencer: AXI-Lite slave model, expected-write queue and
// per-cycle protocol checks, driven by directed scenarios.
module tb_temac_cfg_sequencer;
  localparam logic [7:0] A_RX = 8'h04, A_TX = 8'h08, A_FC = 8'h0C, A_SPD = 8'h10;

  logic        s_axi_aclk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_rx_word = 32'h1111_0001;
  logic [31:0] cfg_tx_word = 32'h2222_0002;
  logic [31:0] cfg_fc_word = 32'h3333_0003;
  logic [1:0]  inband_clock_speed = 2'b10;
  logic [7:0]  m_axi_awaddr, m_axi_araddr;
  logic [31:0] m_axi_wdata;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic [31:0] m_axi_rdata = 32'h0;
  logic        cfg_busy, cfg_done, cfg_error;

  temac_cfg_sequencer dut (
    .s_axi_aclk(s_axi_aclk), .reset(reset), .cfg_start(cfg_start),
    .cfg_rx_word(cfg_rx_word), .cfg_tx_word(cfg_tx_word), .cfg_fc_word(cfg_fc_word),
    .inband_clock_speed(inband_clock_speed),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int n_chk = 0, n_fail = 0;

  // slave knobs
  int          aw_delay = 0, w_delay = 0;
  logic [7:0]  err_addr = 8'hFF, mute_addr = 8'hFF;
  logic [31:0] rdata_val = 32'h8000_0000;

  // model state
  logic [39:0] exp_wr[$];
  int          wr_count = 0, rd_count = 0, aw_len = 0, w_len = 0, b_len_rx = 0;
  int          aw_run = 0, w_run = 0, b_run = 0;
  logic [31:0] last_spd_data = 32'h0;
  logic [7:0]  last_addr = 8'hFF, cur_addr = 8'h00, prev_awaddr = 8'h00;
  logic [31:0] cur_data = 32'h0, prev_wdata = 32'h0;
  logic        got_aw = 0, got_w = 0, wr_cmpl = 0, aw_pend = 0, w_pend = 0, prev_bready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // speed register contents implied by an inband code (reserved code written as 1000M)
  function automatic logic [31:0] spd_word(input logic [1:0] s);
    return {((s == 2'b11) ? 2'b10 : s), 30'b0};
  endfunction

  task automatic push_seq(input logic [1:0] spd);
    exp_wr.push_back({A_RX, cfg_rx_word});
    exp_wr.push_back({A_TX, cfg_tx_word});
    exp_wr.push_back({A_FC, cfg_fc_word});
    exp_wr.push_back({A_SPD, spd_word(spd)});
  endtask

  always @(negedge s_axi_aclk) begin
    logic [39:0] e;
    if (reset) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
      got_aw = 0; got_w = 0; wr_cmpl = 0; aw_pend = 0; w_pend = 0; prev_bready = 0;
      aw_run = 0; w_run = 0; b_run = 0;
    end else begin
      if (aw_pend) begin
        check("awvalid_held", 32'(m_axi_awvalid), 32'd1);
        check("awaddr_stable", 32'(m_axi_awaddr), 32'(prev_awaddr));
      end
      if (w_pend) begin
        check("wvalid_held", 32'(m_axi_wvalid), 32'd1);
        check("wdata_stable", m_axi_wdata, prev_wdata);
      end
      if (m_axi_bready) check("bready_after_aw_w", 32'(wr_cmpl), 32'd1);
      if (prev_bready && !m_axi_bready) begin
        if (last_addr == A_SPD) check("read_follows_speed", 32'(m_axi_arvalid), 32'd1);
        else                    check("next_write_follows", 32'(m_axi_awvalid), 32'd1);
        if (last_addr == A_RX) b_len_rx = b_run;
        wr_cmpl = 0;
      end
      aw_run = m_axi_awvalid ? aw_run + 1 : 0;
      w_run  = m_axi_wvalid  ? w_run + 1  : 0;
      b_run  = m_axi_bready  ? b_run + 1  : 0;

      m_axi_awready = m_axi_awvalid && (aw_run > aw_delay);
      m_axi_wready  = m_axi_wvalid && (w_run > w_delay);
      m_axi_bvalid  = m_axi_bready && (last_addr != mute_addr);
      m_axi_bresp   = (last_addr == err_addr) ? 2'b10 : 2'b00;
      m_axi_arready = m_axi_arvalid;
      m_axi_rvalid  = m_axi_rready;
      m_axi_rdata   = rdata_val;
      m_axi_rresp   = 2'b00;

      // handshakes that complete on the coming rising edge
      if (m_axi_awvalid && m_axi_awready) begin got_aw = 1; cur_addr = m_axi_awaddr; aw_len = aw_run; end
      if (m_axi_wvalid && m_axi_wready) begin got_w = 1; cur_data = m_axi_wdata; w_len = w_run; end
      if (got_aw && got_w) begin
        if (exp_wr.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: addr %h data %h, expected none", cur_addr, cur_data);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(cur_addr), 32'(e[39:32]));
          check("wr_data", cur_data, e[31:0]);
        end
        wr_count++;
        last_addr = cur_addr;
        if (cur_addr == A_SPD) last_spd_data = cur_data;
        got_aw = 0; got_w = 0; wr_cmpl = 1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        rd_count++;
        check("araddr", 32'(m_axi_araddr), 32'(A_SPD));
      end
      aw_pend = m_axi_awvalid && !m_axi_awready;
      w_pend  = m_axi_wvalid && !m_axi_wready;
      prev_awaddr = m_axi_awaddr;
      prev_wdata  = m_axi_wdata;
      prev_bready = m_axi_bready;
    end
  end

  task automatic wait_done(input int budget, input string name);
    int i = 0;
    while (i < budget && !(cfg_done && !cfg_busy)) begin
      @(negedge s_axi_aclk);
      i++;
    end
    check({name, "_reached_done"}, 32'(i < budget), 32'd1);
  endtask

  task automatic wait_busy(input int budget, input string name);
    int i = 0;
    while (i < budget && !cfg_busy) begin
      @(negedge s_axi_aclk);
      i++;
    end
    check({name, "_busy_seen"}, 32'(i < budget), 32'd1);
  endtask

  task automatic first_aw(output int k);
    k = 0;
    while (k < 40) begin
      @(negedge s_axi_aclk);
      k++;
      if (m_axi_awvalid) break;
    end
  endtask

  task automatic pulse_start();
    @(negedge s_axi_aclk) cfg_start = 1'b1;
    @(negedge s_axi_aclk) cfg_start = 1'b0;
  endtask

  initial begin
    int k, wc0, rc0, i;
    // 1: reset values, start delay, full sequence
    push_seq(2'b10);
    repeat (4) @(negedge s_axi_aclk);
    check("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
    check("rst_bready", 32'(m_axi_bready), 32'd0);
    check("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("rst_rready", 32'(m_axi_rready), 32'd0);
    check("rst_awaddr", 32'(m_axi_awaddr), 32'd0);
    check("rst_wdata", m_axi_wdata, 32'd0);
    check("rst_busy_done_err", 32'({cfg_busy, cfg_done, cfg_error}), 32'd0);
    reset = 1'b0;
    first_aw(k);
    check("first_awvalid_cycle", 32'(k), 32'd17);
    check("busy_in_first_write", 32'(cfg_busy), 32'd1);
    wait_done(200, "seq1");
    check("seq1_done", 32'(cfg_done), 32'd1);
    check("seq1_error", 32'(cfg_error), 32'd0);
    check("seq1_writes", 32'(wr_count), 32'd4);
    check("seq1_reads", 32'(rd_count), 32'd1);
    check("seq1_speed_data", last_spd_data, 32'h8000_0000);
    check("seq1_queue_drained", 32'(exp_wr.size()), 32'd0);

    // 2: awready delayed 3 cycles, wready immediate
    aw_delay = 3;
    cfg_rx_word = 32'hA5A5_0004;
    push_seq(2'b10);
    wc0 = wr_count;
    pulse_start();
    check("start_clears_done", 32'(cfg_done), 32'd0);
    wait_done(300, "seq2");
    check("seq2_writes", 32'(wr_count - wc0), 32'd4);
    check("awvalid_len", 32'(aw_len), 32'd4);
    check("wvalid_len", 32'(w_len), 32'd1);
    aw_delay = 0;

    // 3: error response on the TX entry
    err_addr = A_TX;
    push_seq(2'b10);
    wc0 = wr_count;
    pulse_start();
    wait_done(200, "seq3");
    check("bresp_err_flag", 32'(cfg_error), 32'd1);
    check("seq3_done", 32'(cfg_done), 32'd1);
    check("seq3_writes", 32'(wr_count - wc0), 32'd4);
    repeat (5) @(negedge s_axi_aclk);
    check("error_sticky", 32'(cfg_error), 32'd1);
    err_addr = 8'hFF;

    // 4: no write response on entry 0 -> timeout
    mute_addr = A_RX;
    push_seq(2'b10);
    wc0 = wr_count;
    pulse_start();
    check("start_clears_error", 32'(cfg_error), 32'd0);
    wait_done(1400, "seq4");
    check("bready_timeout_len", 32'(b_len_rx), 32'd1023);
    check("timeout_err_flag", 32'(cfg_error), 32'd1);
    check("seq4_writes", 32'(wr_count - wc0), 32'd4);
    mute_addr = 8'hFF;

    push_seq(2'b10);
    pulse_start();
    wait_done(200, "seq_clean");
    check("clean_error", 32'(cfg_error), 32'd0);

    // 5: link speed 1000M -> 100M while DONE
    rdata_val = 32'h4000_0000;
    exp_wr.push_back({A_SPD, spd_word(2'b01)});
    wc0 = wr_count; rc0 = rd_count;
    inband_clock_speed = 2'b01;
    wait_busy(20, "spd_upd");
    i = 0;
    while (i < 100 && cfg_busy) begin
      check("done_held_in_update", 32'(cfg_done), 32'd1);
      @(negedge s_axi_aclk);
      i++;
    end
    check("spd_upd_writes", 32'(wr_count - wc0), 32'd1);
    check("spd_upd_reads", 32'(rd_count - rc0), 32'd1);
    check("spd_upd_data", last_spd_data, 32'h4000_0000);
    check("spd_upd_error", 32'(cfg_error), 32'd0);

    // reserved code is written as 1000M and must not retrigger
    rdata_val = 32'h8000_0000;
    exp_wr.push_back({A_SPD, spd_word(2'b11)});
    wc0 = wr_count;
    inband_clock_speed = 2'b11;
    wait_busy(20, "spd_rsv");
    wait_done(100, "spd_rsv");
    repeat (30) @(negedge s_axi_aclk);
    check("spd_rsv_writes", 32'(wr_count - wc0), 32'd1);
    check("spd_rsv_data", last_spd_data, 32'h8000_0000);
    check("spd_rsv_error", 32'(cfg_error), 32'd0);

    // 6: reset while awvalid is held, then start pulse while busy
    aw_delay = 6;
    push_seq(2'b11);
    pulse_start();
    i = 0;
    while (i < 10 && !m_axi_awvalid) begin @(negedge s_axi_aclk); i++; end
    check("awvalid_before_reset", 32'(m_axi_awvalid), 32'd1);
    reset = 1'b1;
    @(negedge s_axi_aclk);
    check("reset_mid_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 32'd0);
    check("reset_mid_status", 32'({cfg_busy, cfg_done, cfg_error}), 32'd0);
    exp_wr.delete();
    aw_delay = 0;
    push_seq(2'b11);
    wc0 = wr_count; rc0 = rd_count;
    @(negedge s_axi_aclk);
    reset = 1'b0;
    first_aw(k);
    check("restart_awvalid_cycle", 32'(k), 32'd17);
    i = 0;
    while (i < 50 && wr_count == wc0) begin @(negedge s_axi_aclk); i++; end
    check("busy_at_ignored_start", 32'(cfg_busy), 32'd1);
    pulse_start();
    wait_done(200, "seq6");
    check("seq6_writes", 32'(wr_count - wc0), 32'd4);
    check("seq6_reads", 32'(rd_count - rc0), 32'd1);
    check("seq6_queue_drained", 32'(exp_wr.size()), 32'd0);
    repeat (5) @(negedge s_axi_aclk);
    check("seq6_no_extra_writes", 32'(wr_count - wc0), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
